// File: rtl/rv_execute.sv
// rv_execute: execute/writeback stage of the step-by-step RV32I core.
// Three-cycle IDLE/REGS/EXEC sequencer with a 32x32 register file.
module rv_execute #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  output logic        done,
  output logic [31:0] next_pc,
  output logic        unsupported,
  output logic        halted,
  input  logic [4:0]  dbg_reg_id,
  output logic [31:0] dbg_reg_data
);

  typedef enum logic [1:0] {
    IDLE,
    REGS,
    EXEC
  } state_t;

  state_t      state;
  logic [31:0] ir;
  logic [31:0] pcr;
  logic [31:0] rs1v;
  logic [31:0] rs2v;
  logic [31:0] rf [32];

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;

  assign opc = ir[6:0];
  assign f3  = ir[14:12];
  assign rd  = ir[11:7];
  assign rs1 = ir[19:15];
  assign rs2 = ir[24:20];

  logic is_alur;
  logic is_alui;
  logic is_alu;
  logic is_br;
  logic is_jal;
  logic is_jalr;
  logic is_lui;
  logic is_auipc;
  logic is_sys;

  assign is_alur  = (opc == 7'b0110011);
  assign is_alui  = (opc == 7'b0010011);
  assign is_alu   = is_alur | is_alui;
  assign is_br    = (opc == 7'b1100011);
  assign is_jal   = (opc == 7'b1101111);
  assign is_jalr  = (opc == 7'b1100111);
  assign is_lui   = (opc == 7'b0110111);
  assign is_auipc = (opc == 7'b0010111);
  assign is_sys   = (opc == 7'b1110011);

  logic [31:0] immi;
  logic [31:0] immb;
  logic [31:0] immj;
  logic [31:0] immu;

  assign immi = {{20{ir[31]}}, ir[31:20]};
  assign immb = {{20{ir[31]}}, ir[7], ir[30:25],
                 ir[11:8], 1'b0};
  assign immj = {{12{ir[31]}}, ir[19:12], ir[20],
                 ir[30:21], 1'b0};
  assign immu = {ir[31:12], 12'b0};

  logic [31:0] op2;
  logic [4:0]  sh;
  logic [31:0] sra;
  logic [31:0] alu;

  assign op2 = is_alur ? rs2v : immi;
  assign sh  = op2[4:0];
  assign sra = $signed(rs1v) >>> sh;

  // ALU result selected by funct3
  always_comb begin
    alu = '0;
    unique case (f3)
      3'b000: alu = (is_alur && ir[30]) ? rs1v - op2
                                         : rs1v + op2;
      3'b001: alu = rs1v << sh;
      3'b010: alu = {31'b0, $signed(rs1v) < $signed(op2)};
      3'b011: alu = {31'b0, rs1v < op2};
      3'b100: alu = rs1v ^ op2;
      3'b101: alu = ir[30] ? sra : (rs1v >> sh);
      3'b110: alu = rs1v | op2;
      3'b111: alu = rs1v & op2;
      default: alu = '0;
    endcase
  end

  logic take;

  // Branch comparator; 010/011 never taken
  always_comb begin
    take = 1'b0;
    unique case (f3)
      3'b000: take = (rs1v == rs2v);
      3'b001: take = (rs1v != rs2v);
      3'b100: take = $signed(rs1v) < $signed(rs2v);
      3'b101: take = $signed(rs1v) >= $signed(rs2v);
      3'b110: take = rs1v < rs2v;
      3'b111: take = rs1v >= rs2v;
      default: take = 1'b0;
    endcase
  end

  logic        wr;
  logic [31:0] wv;
  logic [31:0] npc;
  logic        uns;
  logic        sys;

  // Writeback value and next PC per opcode class
  always_comb begin
    wr  = 1'b0;
    wv  = '0;
    npc = pcr + 32'd4;
    uns = 1'b0;
    sys = 1'b0;
    unique case (1'b1)
      is_alu: begin
        wr = 1'b1;
        wv = alu;
      end
      is_br: begin
        if (take) npc = pcr + immb;
      end
      is_jal: begin
        wr  = 1'b1;
        wv  = pcr + 32'd4;
        npc = pcr + immj;
      end
      is_jalr: begin
        wr  = 1'b1;
        wv  = pcr + 32'd4;
        npc = (rs1v + immi) & ~32'd1;
      end
      is_lui: begin
        wr = 1'b1;
        wv = immu;
      end
      is_auipc: begin
        wr = 1'b1;
        wv = pcr + immu;
      end
      is_sys: sys = 1'b1;
      default: uns = 1'b1;
    endcase
  end

  assign instr_ready = (state == IDLE) && !halted;

  assign dbg_reg_data = (dbg_reg_id == 5'd0) ? 32'd0
                                             : rf[dbg_reg_id];

  // Sequencer, register file and registered outputs
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= IDLE;
      next_pc     <= RESET_PC;
      done        <= 1'b0;
      unsupported <= 1'b0;
      halted      <= 1'b0;
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else begin
      done        <= 1'b0;
      unsupported <= 1'b0;
      unique case (state)
        IDLE: begin
          if (instr_valid && !halted) begin
            ir    <= instr;
            pcr   <= pc;
            state <= REGS;
          end
        end
        REGS: begin
          rs1v  <= rf[rs1];
          rs2v  <= rf[rs2];
          state <= EXEC;
        end
        EXEC: begin
          if (wr && rd != 5'd0) rf[rd] <= wv;
          next_pc     <= npc;
          done        <= 1'b1;
          unsupported <= uns;
          if (sys) halted <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rv_execute.sv
// tb_rv_execute: randomized and directed checks of rv_execute
// against an instruction-level reference model.
module tb_rv_execute;

  logic        clk = 1'b0;
  logic        resetn;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        done;
  logic [31:0] next_pc;
  logic        unsupported;
  logic        halted;
  logic [4:0]  dbg_reg_id;
  logic [31:0] dbg_reg_data;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] mreg [32];
  logic        mhalt;
  logic [31:0] mnpc;

  rv_execute #(.RESET_PC(32'h0)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr        (instr),
    .pc           (pc),
    .done         (done),
    .next_pc      (next_pc),
    .unsupported  (unsupported),
    .halted       (halted),
    .dbg_reg_id   (dbg_reg_id),
    .dbg_reg_data (dbg_reg_data)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_B  = 7'b1100011;
  localparam logic [6:0] OP_J  = 7'b1101111;
  localparam logic [6:0] OP_JR = 7'b1100111;
  localparam logic [6:0] OP_LU = 7'b0110111;
  localparam logic [6:0] OP_AU = 7'b0010111;
  localparam logic [6:0] OP_SY = 7'b1110011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;

  function automatic logic [31:0] enc_i(
    input logic [11:0] imm, input logic [4:0] rs1,
    input logic [2:0] f3, input logic [4:0] rd,
    input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_r(
    input logic [6:0] f7, input logic [4:0] rs2,
    input logic [4:0] rs1, input logic [2:0] f3,
    input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, OP_R};
  endfunction

  function automatic logic [31:0] enc_b(
    input logic [12:0] imm, input logic [4:0] rs2,
    input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3,
            imm[4:1], imm[11], OP_B};
  endfunction

  function automatic logic [31:0] enc_j(
    input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12],
            rd, OP_J};
  endfunction

  function automatic logic [31:0] enc_u(
    input logic [19:0] imm, input logic [4:0] rd,
    input logic [6:0] op);
    return {imm, rd, op};
  endfunction

  function automatic logic [31:0] sx(
    input logic [31:0] v, input int bits);
    logic [31:0] m;
    m = 32'hFFFF_FFFF << bits;
    return v[bits-1] ? (v | m) : (v & ~m);
  endfunction

  // Instruction-level model: architectural effect of one instruction
  task automatic model(input logic [31:0] i,
                       input logic [31:0] p,
                       output logic [31:0] npc,
                       output logic uns);
    logic [31:0] a, b, o2, r, iimm, bimm, jimm, uimm;
    logic wr, tk;
    a = mreg[i[19:15]];
    b = mreg[i[24:20]];
    iimm = sx({20'b0, i[31:20]}, 12);
    bimm = sx({19'b0, i[31], i[7], i[30:25], i[11:8], 1'b0}, 13);
    jimm = sx({11'b0, i[31], i[19:12], i[20], i[30:21], 1'b0}, 21);
    uimm = {i[31:12], 12'b0};
    npc = p + 4;
    uns = 1'b0;
    wr = 1'b0;
    r = 0;
    tk = 1'b0;
    case (i[6:0])
      OP_R, OP_I: begin
        wr = 1'b1;
        o2 = (i[6:0] == OP_R) ? b : iimm;
        case (i[14:12])
          3'd0: begin
            if (i[6:0] == OP_R && i[30]) r = a - o2;
            else r = a + o2;
          end
          3'd1: r = a << o2[4:0];
          3'd2: r = ($signed(a) < $signed(o2)) ? 1 : 0;
          3'd3: r = (a < o2) ? 1 : 0;
          3'd4: r = a ^ o2;
          3'd5: begin
            if (i[30]) r = $signed(a) >>> o2[4:0];
            else r = a >> o2[4:0];
          end
          3'd6: r = a | o2;
          default: r = a & o2;
        endcase
      end
      OP_B: begin
        case (i[14:12])
          3'd0: tk = (a == b);
          3'd1: tk = (a != b);
          3'd4: tk = ($signed(a) < $signed(b));
          3'd5: tk = ($signed(a) >= $signed(b));
          3'd6: tk = (a < b);
          3'd7: tk = (a >= b);
          default: tk = 1'b0;
        endcase
        if (tk) npc = p + bimm;
      end
      OP_J: begin
        wr = 1'b1; r = p + 4; npc = p + jimm;
      end
      OP_JR: begin
        wr = 1'b1; r = p + 4; npc = (a + iimm) & ~32'd1;
      end
      OP_LU: begin wr = 1'b1; r = uimm; end
      OP_AU: begin wr = 1'b1; r = p + uimm; end
      OP_SY: mhalt = 1'b1;
      default: uns = 1'b1;
    endcase
    if (wr && i[11:7] != 0) mreg[i[11:7]] = r;
    mnpc = npc;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 32; k++) mreg[k] = 0;
    mhalt = 1'b0;
    mnpc = 0;
  endtask

  task automatic do_reset();
    instr_valid = 1'b0;
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    model_reset();
  endtask

  // Issue one instruction and check timing, outputs and register file
  task automatic exec_instr(input logic [31:0] ins,
                            input logic [31:0] p);
    logic [31:0] enpc, old;
    logic euns;
    logic [4:0] rd;
    int lat, bad;
    rd = ins[11:7];
    old = mreg[rd];
    model(ins, p, enpc, euns);
    @(negedge clk);
    vectors++;
    if (instr_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL ready_idle: got %b want 1", instr_ready);
    end
    instr_valid = 1'b1;
    instr = ins;
    pc = p;
    dbg_reg_id = rd;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    instr = $urandom;
    pc = $urandom;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 2) begin
        vectors++;
        if (dbg_reg_data !== old) begin
          miscompares++;
          $display("FAIL dbg_old x%0d: got %h want %h",
                   rd, dbg_reg_data, old);
        end
      end
    end while (!done && lat < 8);
    vectors++;
    if (lat != 3 || done !== 1'b1) begin
      miscompares++;
      $display("FAIL latency %h: got %0d want 3", ins, lat);
    end
    vectors++;
    if (next_pc !== enpc) begin
      miscompares++;
      $display("FAIL next_pc %h@%h: got %h want %h",
               ins, p, next_pc, enpc);
    end
    vectors++;
    if (unsupported !== euns || halted !== mhalt) begin
      miscompares++;
      $display("FAIL flags %h: got uns=%b hlt=%b want %b %b",
               ins, unsupported, halted, euns, mhalt);
    end
    vectors++;
    if (instr_ready !== !mhalt) begin
      miscompares++;
      $display("FAIL ready_done: got %b want %b",
               instr_ready, !mhalt);
    end
    @(negedge clk);
    vectors++;
    if (done !== 1'b0 || unsupported !== 1'b0) begin
      miscompares++;
      $display("FAIL pulse_width: got done=%b uns=%b want 0 0",
               done, unsupported);
    end
    bad = 0;
    for (int k = 0; k < 32; k++) begin
      dbg_reg_id = k[4:0];
      #1;
      if (dbg_reg_data !== mreg[k]) begin
        bad++;
        $display("FAIL regfile x%0d: got %h want %h",
                 k, dbg_reg_data, mreg[k]);
      end
    end
    vectors++;
    if (bad != 0) miscompares++;
  endtask

  task automatic test_reset();
    int bad;
    do_reset();
    vectors++;
    if (next_pc !== 32'h0 || done !== 1'b0 ||
        unsupported !== 1'b0 || halted !== 1'b0 ||
        instr_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset: got npc=%h d=%b u=%b h=%b r=%b want 0 0 0 0 1",
               next_pc, done, unsupported, halted, instr_ready);
    end
    bad = 0;
    for (int k = 0; k < 32; k++) begin
      dbg_reg_id = k[4:0];
      #1;
      if (dbg_reg_data !== 32'h0) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL reset_regs: got %0d nonzero want 0", bad);
    end
  endtask

  task automatic test_basic();
    exec_instr(enc_i(12'd5, 5'd0, 3'd0, 5'd1, OP_I), 32'd0);
    vectors++;
    if (next_pc !== 32'd4) begin
      miscompares++;
      $display("FAIL basic_npc1: got %h want 4", next_pc);
    end
    exec_instr(enc_r(7'd0, 5'd1, 5'd1, 3'd0, 5'd2), 32'd4);
    dbg_reg_id = 5'd2;
    #1;
    vectors++;
    if (next_pc !== 32'd8 || dbg_reg_data !== 32'd10) begin
      miscompares++;
      $display("FAIL basic_add: got npc=%h x2=%h want 8 a",
               next_pc, dbg_reg_data);
    end
  endtask

  task automatic test_alu();
    logic [4:0]  ids [5];
    logic [31:0] exp [5];
    ids = '{5'd3, 5'd5, 5'd6, 5'd7, 5'd8};
    exp = '{32'hFFFF_FFFE, 32'hFFFF_FFFC, 32'h3FFF_FFFC,
            32'd1, 32'd0};
    exec_instr(enc_i(12'd3, 5'd0, 3'd0, 5'd1, OP_I), 32'd0);
    exec_instr(enc_i(12'd5, 5'd0, 3'd0, 5'd2, OP_I), 32'd4);
    exec_instr(enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd3), 32'd8);
    exec_instr(enc_i(12'hFF0, 5'd0, 3'd0, 5'd4, OP_I), 32'd12);
    exec_instr(enc_i(12'h402, 5'd4, 3'd5, 5'd5, OP_I), 32'd16);
    exec_instr(enc_i(12'h002, 5'd4, 3'd5, 5'd6, OP_I), 32'd20);
    exec_instr(enc_r(7'd0, 5'd4, 5'd1, 3'd3, 5'd7), 32'd24);
    exec_instr(enc_r(7'd0, 5'd4, 5'd1, 3'd2, 5'd8), 32'd28);
    for (int k = 0; k < 5; k++) begin
      dbg_reg_id = ids[k];
      #1;
      vectors++;
      if (dbg_reg_data !== exp[k]) begin
        miscompares++;
        $display("FAIL alu x%0d: got %h want %h",
                 ids[k], dbg_reg_data, exp[k]);
      end
    end
  endtask

  task automatic test_branch();
    exec_instr(enc_b(13'h1FF8, 5'd1, 5'd1, 3'd0), 32'd8);
    vectors++;
    if (next_pc !== 32'd0) begin
      miscompares++;
      $display("FAIL beq: got %h want 0", next_pc);
    end
    exec_instr(enc_b(13'h1FF8, 5'd1, 5'd1, 3'd1), 32'd8);
    vectors++;
    if (next_pc !== 32'd12) begin
      miscompares++;
      $display("FAIL bne: got %h want c", next_pc);
    end
    exec_instr(enc_b(13'd16, 5'd1, 5'd4, 3'd4), 32'd8);
    vectors++;
    if (next_pc !== 32'd24) begin
      miscompares++;
      $display("FAIL blt: got %h want 18", next_pc);
    end
    exec_instr(enc_b(13'd16, 5'd1, 5'd1, 3'd2), 32'd8);
  endtask

  task automatic test_jumps();
    exec_instr(enc_j(21'd12, 5'd1), 32'd16);
    vectors++;
    if (next_pc !== 32'd28 || mreg[1] !== 32'd20) begin
      miscompares++;
      $display("FAIL jal: got npc=%h want 1c", next_pc);
    end
    exec_instr(enc_i(12'h101, 5'd0, 3'd0, 5'd2, OP_I), 32'd28);
    exec_instr(enc_i(12'd0, 5'd2, 3'd0, 5'd2, OP_JR), 32'h40);
    dbg_reg_id = 5'd2;
    #1;
    vectors++;
    if (next_pc !== 32'h100 || dbg_reg_data !== 32'h44) begin
      miscompares++;
      $display("FAIL jalr: got npc=%h x2=%h want 100 44",
               next_pc, dbg_reg_data);
    end
    exec_instr(enc_u(20'h12345, 5'd3, OP_LU), 32'h100);
    dbg_reg_id = 5'd3;
    #1;
    vectors++;
    if (dbg_reg_data !== 32'h1234_5000) begin
      miscompares++;
      $display("FAIL lui: got %h want 12345000", dbg_reg_data);
    end
    exec_instr(enc_u(20'h1, 5'd3, OP_AU), 32'd8);
    dbg_reg_id = 5'd3;
    #1;
    vectors++;
    if (dbg_reg_data !== 32'h1008) begin
      miscompares++;
      $display("FAIL auipc: got %h want 1008", dbg_reg_data);
    end
  endtask

  task automatic test_misc();
    exec_instr(enc_i(12'd7, 5'd0, 3'd0, 5'd0, OP_I), 32'h20);
    exec_instr(enc_i(12'd0, 5'd1, 3'd2, 5'd5, OP_LD), 32'h24);
    vectors++;
    if (next_pc !== 32'h28) begin
      miscompares++;
      $display("FAIL lw_npc: got %h want 28", next_pc);
    end
    exec_instr({7'd0, 5'd2, 5'd1, 3'd2, 5'd0, OP_ST}, 32'h28);
    exec_instr({25'h1ABCDE, 7'h7F}, 32'h2C);
  endtask

  task automatic test_random();
    logic [6:0] ops [9];
    logic [31:0] w, p;
    ops = '{OP_R, OP_I, OP_B, OP_J, OP_JR, OP_LU, OP_AU,
            OP_LD, OP_ST};
    for (int n = 0; n < 20; n++) begin
      w = $urandom;
      exec_instr({w[31:7], OP_LU}, 32'd0);
    end
    for (int n = 0; n < 200; n++) begin
      w = $urandom;
      p = $urandom;
      p[1:0] = 2'b00;
      exec_instr({w[31:7], ops[$urandom_range(0, 8)]}, p);
    end
  endtask

  task automatic test_reset_midflight();
    int pulses;
    exec_instr(enc_i(12'd1, 5'd0, 3'd0, 5'd2, OP_I), 32'h10);
    @(negedge clk);
    instr_valid = 1'b1;
    instr = enc_i(12'd9, 5'd0, 3'd0, 5'd1, OP_I);
    pc = 32'h14;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    model_reset();
    #1;
    vectors++;
    if (instr_ready !== 1'b1 || next_pc !== 32'd0 ||
        halted !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset: got r=%b npc=%h h=%b d=%b want 1 0 0 0",
               instr_ready, next_pc, halted, done);
    end
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      if (done) pulses++;
    end
    dbg_reg_id = 5'd1;
    #1;
    vectors++;
    if (pulses != 0 || dbg_reg_data !== 32'd0) begin
      miscompares++;
      $display("FAIL midreset_wb: got pulses=%0d x1=%h want 0 0",
               pulses, dbg_reg_data);
    end
  endtask

  task automatic test_halt();
    exec_instr(32'h0010_0073, 32'h30);
    instr_valid = 1'b1;
    instr = enc_i(12'd1, 5'd0, 3'd0, 5'd1, OP_I);
    pc = 32'h34;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      vectors++;
      if (instr_ready !== 1'b0 || done !== 1'b0 ||
          halted !== 1'b1) begin
        miscompares++;
        $display("FAIL halt_hold %0d: got r=%b d=%b h=%b want 0 0 1",
                 n, instr_ready, done, halted);
      end
    end
    instr_valid = 1'b0;
    vectors++;
    if (next_pc !== 32'h34) begin
      miscompares++;
      $display("FAIL halt_npc: got %h want 34", next_pc);
    end
  endtask

  initial begin
    resetn = 1'b0;
    instr_valid = 1'b0;
    instr = '0;
    pc = '0;
    dbg_reg_id = '0;
    model_reset();
    test_reset();
    test_basic();
    test_alu();
    test_branch();
    test_jumps();
    test_misc();
    test_random();
    test_reset_midflight();
    test_halt();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
